// File: rtl/reg_bank_pkg.sv
// Shared types, defaults and address decode for the register bank reader.
// The lock feature in reg_bank_reader is enabled by defining REG_BANK_READ_LOCK_EN.
package reg_bank_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int NUM_REGS_DEF = 4;
    localparam int CODE_W       = 6;

    // Register-select codes live in address bits [8:3]; code 1 is the highest register.
    localparam logic [CODE_W-1:0] ADDR_CODE_PC3 = 6'd1;
    localparam logic [CODE_W-1:0] ADDR_CODE_PC2 = 6'd2;
    localparam logic [CODE_W-1:0] ADDR_CODE_PC1 = 6'd3;
    localparam logic [CODE_W-1:0] ADDR_CODE_PC0 = 6'd4;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        RESP,
        SCRUB
    } state_t;

    typedef struct packed {
        logic              valid;
        logic [CODE_W-1:0] idx;
    } decode_t;

    function automatic decode_t decode_addr(input logic [CODE_W-1:0] code, input int num_regs);
        decode_t d;
        d.valid = 1'b0;
        d.idx   = '0;
        if (int'(code) >= int'(ADDR_CODE_PC3) && int'(code) < int'(ADDR_CODE_PC3) + num_regs) begin
            d.valid = 1'b1;
            d.idx   = CODE_W'(num_regs - int'(code));
        end
        return d;
    endfunction

endpackage

// File: rtl/reg_bank_reader.sv
// Single-outstanding read port onto a register bank with response holding and scrubbing.
// Optional per-register read locking is enabled by defining REG_BANK_READ_LOCK_EN.
module reg_bank_reader
    import reg_bank_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             req_valid_i,
    output logic                             req_ready_o,
    input  logic [8:0]                       req_addr_i,
    input  logic [NUM_REGS-1:0]              reglk_ctrl_i,
    input  logic [NUM_REGS-1:0][DATA_W-1:0]  p_c_i,
    output logic                             rsp_valid_o,
    input  logic                             rsp_ready_i,
    output logic [DATA_W-1:0]                rsp_rdata_o,
    output logic                             rsp_err_o
);

    state_t            state;
    state_t            state_n;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_n;
    logic              err_q;
    logic              err_n;
    logic [CODE_W-1:0] addr_q;
    logic [CODE_W-1:0] addr_n;
    decode_t           dec;
    logic [DATA_W-1:0] sel_data;
    logic              sel_lock;

    // Decode the latched register code and pick the addressed bank entry.
    always_comb begin
        dec      = decode_addr(addr_q, NUM_REGS);
        sel_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (dec.valid && dec.idx == CODE_W'(i)) begin
                sel_data = p_c_i[i];
            end
        end
    end

`ifdef REG_BANK_READ_LOCK_EN
    always_comb begin
        sel_lock = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (dec.valid && dec.idx == CODE_W'(i)) begin
                sel_lock = reglk_ctrl_i[i];
            end
        end
    end
`else
    logic unused_lock;
    assign sel_lock    = 1'b0;
    assign unused_lock = ^reglk_ctrl_i;
`endif

    logic unused_addr;
    assign unused_addr = ^req_addr_i[2:0];

    always_comb begin
        state_n = state;
        data_n  = data_q;
        err_n   = err_q;
        addr_n  = addr_q;
        case (state)
            IDLE: begin
                if (req_valid_i) begin
                    addr_n  = req_addr_i[8:3];
                    state_n = CAPTURE;
                end
            end
            CAPTURE: begin
                if (!dec.valid || sel_lock) begin
                    data_n = '0;
                    err_n  = 1'b1;
                end else begin
                    data_n = sel_data;
                    err_n  = 1'b0;
                end
                state_n = RESP;
            end
            RESP: begin
                // A lock raised mid-response revokes the data but keeps the response pending.
                if (sel_lock) begin
                    data_n = '0;
                    err_n  = 1'b1;
                end
                if (rsp_ready_i) begin
                    state_n = SCRUB;
                end
            end
            SCRUB: begin
                data_n  = '0;
                err_n   = 1'b0;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            data_q <= '0;
            err_q  <= 1'b0;
            addr_q <= '0;
        end else begin
            state  <= state_n;
            data_q <= data_n;
            err_q  <= err_n;
            addr_q <= addr_n;
        end
    end

    // Response fields are masked so nothing stale is visible while not valid.
    assign req_ready_o = (state == IDLE) && !rst_i;
    assign rsp_valid_o = (state == RESP);
    assign rsp_rdata_o = rsp_valid_o ? data_q : '0;
    assign rsp_err_o   = rsp_valid_o & err_q;

endmodule

// File: tb/tb_reg_bank_reader.sv
// Scoreboard bench for reg_bank_reader; expectations follow REG_BANK_READ_LOCK_EN when defined.
module tb_reg_bank_reader;
    import reg_bank_pkg::*;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             req_valid_i;
    logic             req_ready_o;
    logic [8:0]       req_addr_i;
    logic [3:0]       reglk_ctrl_i;
    logic [3:0][31:0] p_c_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [31:0]      rsp_rdata_o;
    logic             rsp_err_o;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic       LOCK_ON = 
`ifdef REG_BANK_READ_LOCK_EN
        1'b1;
`else
        1'b0;
`endif

    reg_bank_reader #(.DATA_W(32), .NUM_REGS(4)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr_i),
        .reglk_ctrl_i (reglk_ctrl_i),
        .p_c_i        (p_c_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [8:0] addrOf(input logic [CODE_W-1:0] code);
        return {code, 3'b000};
    endfunction

    // Wait for IDLE, issue one request and record what its response must carry.
    task automatic applyStimulus(input logic [8:0] addr, input logic [31:0] d, input logic e);
        exp_t x;
        int   budget = 0;
        while (!req_ready_o && budget < 20) begin
            tick();
            budget++;
        end
        checkOutput("req_ready_wait", 32'(req_ready_o), 32'd1);
        req_valid_i = 1'b1;
        req_addr_i  = addr;
        x.data      = d;
        x.err       = e;
        exp_q.push_back(x);
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic waitResponse();
        int budget = 0;
        while (exp_q.size() != 0 && budget < 50) begin
            tick();
            budget++;
        end
        checkOutput("rsp_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: pop on each response handshake, and insist on zeros whenever not valid.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (rsp_valid_o && rsp_ready_i) begin
                checkOutput("sb_underflow", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    exp_t x;
                    x = exp_q.pop_front();
                    checkOutput("sb_rdata", rsp_rdata_o, x.data);
                    checkOutput("sb_err", 32'(rsp_err_o), 32'(x.err));
                end
            end else if (!rsp_valid_o) begin
                checkOutput("idle_rdata_zero", rsp_rdata_o, 32'd0);
                checkOutput("idle_err_zero", 32'(rsp_err_o), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_i        = 1'b1;
        req_valid_i  = 1'b0;
        req_addr_i   = '0;
        reglk_ctrl_i = '0;
        p_c_i        = '0;
        rsp_ready_i  = 1'b1;
        repeat (2) tick();
        @(negedge clk_i);
        checkOutput("rst_req_ready", 32'(req_ready_o), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        checkOutput("rst_rdata", rsp_rdata_o, 32'd0);
        checkOutput("rst_err", 32'(rsp_err_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("post_rst_ready", 32'(req_ready_o), 32'd1);
        tick();

        // Basic read with latency and scrub checks.
        p_c_i[3] = 32'hDEADBEEF;
        applyStimulus(addrOf(ADDR_CODE_PC3), 32'hDEADBEEF, 1'b0);
        @(negedge clk_i);
        checkOutput("lat_capture_valid", 32'(rsp_valid_o), 32'd0);
        tick();
        @(negedge clk_i);
        checkOutput("lat_resp_valid", 32'(rsp_valid_o), 32'd1);
        checkOutput("lat_resp_ready", 32'(req_ready_o), 32'd0);
        tick();
        @(negedge clk_i);
        checkOutput("scrub_valid", 32'(rsp_valid_o), 32'd0);
        checkOutput("scrub_rdata", rsp_rdata_o, 32'd0);
        tick();
        waitResponse();

        // Invalid codes at both ends of the map, then the last valid code.
        applyStimulus(9'h028, 32'd0, 1'b1);
        waitResponse();
        applyStimulus(9'h000, 32'd0, 1'b1);
        waitResponse();
        applyStimulus(9'h1F8, 32'd0, 1'b1);
        waitResponse();
        p_c_i[0] = 32'h12345678;
        applyStimulus(addrOf(ADDR_CODE_PC0) | 9'h007, 32'h12345678, 1'b0);
        waitResponse();

        // Back-pressure: held data survives bank changes and stray requests are ignored.
        p_c_i[2]    = 32'hA5A5A5A5;
        rsp_ready_i = 1'b0;
        applyStimulus(addrOf(ADDR_CODE_PC2), 32'hA5A5A5A5, 1'b0);
        tick();
        p_c_i[2]    = 32'h0;
        req_valid_i = 1'b1;
        req_addr_i  = addrOf(ADDR_CODE_PC3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            checkOutput("hold_valid", 32'(rsp_valid_o), 32'd1);
            checkOutput("hold_rdata", rsp_rdata_o, 32'hA5A5A5A5);
            checkOutput("hold_req_ready", 32'(req_ready_o), 32'd0);
            tick();
        end
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        tick();
        @(negedge clk_i);
        checkOutput("hold_scrub_rdata", rsp_rdata_o, 32'd0);
        tick();
        waitResponse();

        // Lock at capture time.
        p_c_i[1]     = 32'hCAFEF00D;
        reglk_ctrl_i = 4'b0010;
        applyStimulus(addrOf(ADDR_CODE_PC1), LOCK_ON ? 32'd0 : 32'hCAFEF00D, LOCK_ON);
        waitResponse();
        reglk_ctrl_i = 4'b0000;

        // Lock raised while the response is being held.
        p_c_i[2]    = 32'h0BADC0DE;
        rsp_ready_i = 1'b0;
        applyStimulus(addrOf(ADDR_CODE_PC2), LOCK_ON ? 32'd0 : 32'h0BADC0DE, LOCK_ON);
        tick();
        @(negedge clk_i);
        checkOutput("prelock_rdata", rsp_rdata_o, 32'h0BADC0DE);
        tick();
        reglk_ctrl_i = 4'b0100;
        tick();
        @(negedge clk_i);
        checkOutput("lock_rsp_valid", 32'(rsp_valid_o), 32'd1);
        checkOutput("lock_rdata", rsp_rdata_o, LOCK_ON ? 32'd0 : 32'h0BADC0DE);
        checkOutput("lock_err", 32'(rsp_err_o), 32'(LOCK_ON));
        tick();
        rsp_ready_i = 1'b1;
        waitResponse();
        reglk_ctrl_i = 4'b0000;
        tick();

        // Reset pulse in RESP discards the pending response.
        p_c_i[3]    = 32'h55AA55AA;
        rsp_ready_i = 1'b0;
        applyStimulus(addrOf(ADDR_CODE_PC3), 32'h55AA55AA, 1'b0);
        tick();
        @(negedge clk_i);
        checkOutput("prerst_valid", 32'(rsp_valid_o), 32'd1);
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        exp_q.delete();
        @(negedge clk_i);
        checkOutput("rstresp_valid", 32'(rsp_valid_o), 32'd0);
        checkOutput("rstresp_rdata", rsp_rdata_o, 32'd0);
        checkOutput("rstresp_err", 32'(rsp_err_o), 32'd0);
        checkOutput("rstresp_ready", 32'(req_ready_o), 32'd1);
        tick();

        // Recovery read after the reset.
        rsp_ready_i = 1'b1;
        p_c_i[1]    = 32'h600DF00D;
        applyStimulus(addrOf(ADDR_CODE_PC1), 32'h600DF00D, 1'b0);
        waitResponse();

        repeat (3) tick();
        checkOutput("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
